// File: rtl/seg_codes_pkg.sv
// seg_codes_pkg
// Constants shared between the binary-to-digits converter and the
// seven-segment decoder that consumes its digit codes, plus the converter's
// FSM state encoding.
//   DIGIT_W    : width of one digit code on the display bus
//   NUM_DIGITS : digits per display
//   MAX_VAL    : largest value the display can show
//   CODE_BLANK : digit code that lights no segment
//   CODE_DASH  : digit code that lights only the middle segment
package seg_codes_pkg;

  localparam int DIGIT_W    = 5;
  localparam int NUM_DIGITS = 4;
  localparam int MAX_VAL    = 9999;
  localparam int BIG_W      = DIGIT_W * NUM_DIGITS;

  localparam logic [DIGIT_W-1:0] CODE_BLANK = 5'd16;
  localparam logic [DIGIT_W-1:0] CODE_DASH  = 5'd17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PACK  = 2'd2
  } state_t;

  // A BCD nibble becomes a digit code by zero extension.
  function automatic logic [DIGIT_W-1:0] bcd_code(input logic [3:0] d);
    return {1'b0, d};
  endfunction

endpackage

// File: rtl/bin_to_digits_seq_if.sv
// bin_to_digits_seq_if
// Request/result bundle between a client and the binary-to-digits converter.
//   start   : client -> converter, conversion request
//   bin     : client -> converter, unsigned value to convert
//   busy    : converter -> client, conversion in progress
//   done    : converter -> client, one-cycle pulse, big_bin just updated
//   big_bin : converter -> client, four 5-bit digit codes, units in [4:0]
//
// Handshake: a request is taken on a rising edge where start=1 and the
// converter is idle (busy=0); bin is captured on that same edge only.
// Requests seen while busy=1 are dropped, not queued. The cycle carrying
// done=1 is already idle, so a request in that cycle is taken.
interface bin_to_digits_seq_if #(
  parameter int BIN_W = 14
);
  import seg_codes_pkg::*;

  logic             start;
  logic [BIN_W-1:0] bin;
  logic             busy;
  logic             done;
  logic [BIG_W-1:0] big_bin;

  modport master (
    output start,
    output bin,
    input  busy,
    input  done,
    input  big_bin
  );

  modport slave (
    input  start,
    input  bin,
    output busy,
    output done,
    output big_bin
  );

endinterface

// File: rtl/bin_to_digits_seq_bcd_add3.sv
// bcd_add3
// Double-dabble correction for one BCD nibble: values of 5 or more get 3
// added so the following left shift carries correctly into the next digit.
//   d : accumulator nibble before correction
//   q : corrected nibble (0..12, only 0..9 ever reach it in practice)
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);

  always_comb begin
    q = d;
    if (d >= 4'd5) begin
      q = d + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_digits_seq.sv
// bin_to_digits_seq
// Sequential binary-to-BCD converter feeding a four-digit display.
// A request loads the value, fourteen double-dabble shift cycles follow,
// and a pack cycle writes the four digit codes to big_bin and pulses done.
// Values above 9999 show as four dashes.
//
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous active-low reset
//   bus       : slave side of bin_to_digits_seq_if (start/bin in,
//               busy/done/big_bin out)
//   dbg_state : current FSM state, for observation only
//
// Build option: define LEAD_ZERO_BLANK_EN to replace leading zero digits
// (thousands, hundreds, tens) with CODE_BLANK. Without it leading zeros are
// shown as 0 and no blanking logic exists.
//
// Only BIN_W = 14 is supported.
module bin_to_digits_seq
  import seg_codes_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic                clk,
  input  logic                rst,
  bin_to_digits_seq_if.slave  bus,
  output state_t              dbg_state
);

  localparam int             ACC_W      = 4 * NUM_DIGITS;
  localparam logic [3:0]     LAST_SHIFT = 4'(BIN_W - 1);
  localparam logic [BIN_W-1:0] MAX_BIN  = BIN_W'(MAX_VAL);

  state_t             state;
  state_t             state_nx;
  logic [3:0]         cnt;
  logic [BIN_W-1:0]   sreg;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_fix;
  logic               ovf;
  logic               done_q;
  logic [BIG_W-1:0]   big_q;
  logic [BIG_W-1:0]   pack_codes;

  // Per-digit correction ahead of the shift.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d (acc[g*4 +: 4]),
      .q (acc_fix[g*4 +: 4])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (bus.start) state_nx = ST_SHIFT;
      ST_SHIFT: if (cnt == LAST_SHIFT) state_nx = ST_PACK;
      ST_PACK:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Digit codes as they will be written on the pack edge. In PACK the
  // accumulators already hold the result of the final shift.
  always_comb begin
    pack_codes = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      pack_codes[i*DIGIT_W +: DIGIT_W] = bcd_code(acc[i*4 +: 4]);
    end
`ifdef LEAD_ZERO_BLANK_EN
    // Blank from the most significant side until the first nonzero digit;
    // the units digit always shows.
    if (acc[15:12] == 4'd0) begin
      pack_codes[19:15] = CODE_BLANK;
      if (acc[11:8] == 4'd0) begin
        pack_codes[14:10] = CODE_BLANK;
        if (acc[7:4] == 4'd0) begin
          pack_codes[9:5] = CODE_BLANK;
        end
      end
    end
`endif
    if (ovf) begin
      pack_codes = {NUM_DIGITS{CODE_DASH}};
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt    <= '0;
      sreg   <= '0;
      acc    <= '0;
      ovf    <= 1'b0;
      done_q <= 1'b0;
      big_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            sreg <= bus.bin;
            acc  <= '0;
            cnt  <= '0;
            ovf  <= (bus.bin > MAX_BIN);
          end
        end
        ST_SHIFT: begin
          // Corrected accumulators and the value register shift as one
          // chain, the value's MSB entering the units nibble.
          {acc, sreg} <= {acc_fix, sreg} << 1;
          cnt         <= cnt + 4'd1;
        end
        ST_PACK: begin
          big_q  <= pack_codes;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state != ST_IDLE);
  assign bus.done    = done_q;
  assign bus.big_bin = big_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_bin_to_digits_seq.sv
// tb_bin_to_digits_seq
// Directed bench for bin_to_digits_seq: reset, first start after reset,
// boundary values, busy-time start rejection, start held through a
// conversion with bin changing, and reset mid-conversion.
// Compile with LEAD_ZERO_BLANK_EN defined to check the blanking build.
module tb_bin_to_digits_seq;
  import seg_codes_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;

  bin_to_digits_seq_if #(.BIN_W(14)) bus ();

  bin_to_digits_seq #(.BIN_W(14)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int          pass_cnt  = 0;
  int          total_cnt = 0;
  logic [19:0] last_exp  = 20'd0;

  function automatic logic [19:0] dig4(input int t, input int h, input int te, input int u);
    return {5'(t), 5'(h), 5'(te), 5'(u)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full conversion from an idle converter; edge N is the first step.
  task automatic run_conv(input logic [13:0] v, input logic [19:0] exp, input string name);
    logic bad_busy;
    logic bad_hold;
    bus.start = 1'b1;
    bus.bin   = v;
    step();
    bus.start = 1'b0;
    bus.bin   = 14'($urandom_range(0, 16383));
    bad_busy  = 1'b0;
    bad_hold  = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad_busy = 1'b1;
      if (bus.big_bin !== last_exp) bad_hold = 1'b1;
      if (i < 14) step();
    end
    total_cnt++;
    if (bad_busy !== 1'b0) $display("FAIL %s busy_window: busy/done wrong during N+1..N+15", name);
    else pass_cnt++;
    total_cnt++;
    if (bad_hold !== 1'b0) $display("FAIL %s big_bin_hold: big_bin changed before pack, required %0h", name, last_exp);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) $display("FAIL %s done_pulse: done=%b busy=%b, required done=1 busy=0", name, bus.done, bus.busy);
    else pass_cnt++;
    total_cnt++;
    if (bus.big_bin !== exp) $display("FAIL %s result: got %0h required %0h", name, bus.big_bin, exp);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.done !== 1'b0 || bus.big_bin !== exp) $display("FAIL %s after_done: done=%b big_bin=%0h, required 0 / %0h", name, bus.done, bus.big_bin, exp);
    else pass_cnt++;
    last_exp = exp;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    bus.start = 1'b1;
    bus.bin   = 14'd1234;
    repeat (3) step();
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", bus.busy);
    else pass_cnt++;
    total_cnt++;
    if (bus.done !== 1'b0) $display("FAIL reset_done: got %b required 0", bus.done);
    else pass_cnt++;
    total_cnt++;
    if (bus.big_bin !== 20'd0) $display("FAIL reset_big_bin: got %0h required 0", bus.big_bin);
    else pass_cnt++;
    total_cnt++;
    if (dbg_state !== ST_IDLE) $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE);
    else pass_cnt++;
    last_exp = 20'd0;
  endtask

  task automatic test_first_start();
    rst = 1'b1;
    run_conv(14'd1234, dig4(1, 2, 3, 4), "first_1234");
  endtask

  task automatic test_boundary();
    logic [13:0] vals [10];
    logic [19:0] exps [10];
    vals = '{14'd9999, 14'd10000, 14'd16383, 14'd0, 14'd7,
             14'd1005, 14'd10, 14'd100, 14'd4096, 14'd8421};
`ifdef LEAD_ZERO_BLANK_EN
    exps = '{dig4(9,9,9,9), dig4(17,17,17,17), dig4(17,17,17,17),
             dig4(16,16,16,0), dig4(16,16,16,7), dig4(1,0,0,5),
             dig4(16,16,1,0), dig4(16,1,0,0), dig4(4,0,9,6), dig4(8,4,2,1)};
`else
    exps = '{dig4(9,9,9,9), dig4(17,17,17,17), dig4(17,17,17,17),
             dig4(0,0,0,0), dig4(0,0,0,7), dig4(1,0,0,5),
             dig4(0,0,1,0), dig4(0,1,0,0), dig4(4,0,9,6), dig4(8,4,2,1)};
`endif
    for (int i = 0; i < 10; i++) begin
      run_conv(vals[i], exps[i], $sformatf("bin_%0d", vals[i]));
    end
  endtask

  task automatic test_ignore_busy();
    bus.start = 1'b1;
    bus.bin   = 14'd2468;
    step();
    bus.start = 1'b0;
    repeat (4) step();
    bus.start = 1'b1;
    bus.bin   = 14'd1111;
    step();
    bus.start = 1'b0;
    repeat (10) step();
    total_cnt++;
    if (bus.done !== 1'b1 || bus.big_bin !== dig4(2, 4, 6, 8))
      $display("FAIL ignore_busy_result: done=%b big_bin=%0h required 1 / %0h", bus.done, bus.big_bin, dig4(2, 4, 6, 8));
    else pass_cnt++;
    step();
    step();
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL ignore_busy_no_queue: busy=%b required 0", bus.busy);
    else pass_cnt++;
    last_exp = dig4(2, 4, 6, 8);
  endtask

  task automatic test_start_held();
    int          done_seen;
    logic [19:0] exp42;
`ifdef LEAD_ZERO_BLANK_EN
    exp42 = dig4(16, 16, 4, 2);
`else
    exp42 = dig4(0, 0, 4, 2);
`endif
    done_seen = 0;
    bus.start = 1'b1;
    bus.bin   = 14'd5321;
    step();
    step();
    step();
    bus.bin = 14'd42;
    for (int i = 3; i <= 15; i++) begin
      step();
      if (bus.done === 1'b1) done_seen++;
    end
    total_cnt++;
    if (bus.done !== 1'b1 || bus.big_bin !== dig4(5, 3, 2, 1))
      $display("FAIL held_result: done=%b big_bin=%0h required 1 / %0h", bus.done, bus.big_bin, dig4(5, 3, 2, 1));
    else pass_cnt++;
    step();
    if (bus.done === 1'b1) done_seen++;
    total_cnt++;
    if (done_seen != 1) $display("FAIL held_done_count: got %0d required 1", done_seen);
    else pass_cnt++;
    total_cnt++;
    if (bus.busy !== 1'b1) $display("FAIL held_accept_in_done_cycle: busy=%b required 1", bus.busy);
    else pass_cnt++;
    bus.start = 1'b0;
    repeat (15) step();
    total_cnt++;
    if (bus.done !== 1'b1 || bus.big_bin !== exp42)
      $display("FAIL held_second_result: done=%b big_bin=%0h required 1 / %0h", bus.done, bus.big_bin, exp42);
    else pass_cnt++;
    step();
    last_exp = exp42;
  endtask

  task automatic test_reset_mid();
    logic bad;
    bus.start = 1'b1;
    bus.bin   = 14'd5678;
    step();
    bus.start = 1'b0;
    repeat (7) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    total_cnt++;
    if (bus.busy !== 1'b0 || dbg_state !== ST_IDLE) $display("FAIL mid_reset_busy: busy=%b state=%0d required 0 / idle", bus.busy, dbg_state);
    else pass_cnt++;
    total_cnt++;
    if (bus.big_bin !== 20'd0) $display("FAIL mid_reset_big_bin: got %0h required 0", bus.big_bin);
    else pass_cnt++;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done !== 1'b0 || bus.big_bin !== 20'd0) bad = 1'b1;
      step();
    end
    total_cnt++;
    if (bad !== 1'b0) $display("FAIL mid_reset_quiet: done pulsed or big_bin moved, required done=0 big_bin=0");
    else pass_cnt++;
    last_exp = 20'd0;
    run_conv(14'd5678, dig4(5, 6, 7, 8), "after_mid_reset_5678");
  endtask

  initial begin
    bus.start = 1'b0;
    bus.bin   = '0;
    rst       = 1'b0;
    test_reset();
    test_first_start();
    test_boundary();
    test_ignore_busy();
    test_start_held();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
